maxnet_engine: RTL
==================

Name: maxnet_engine

Overview:
- Consumer stage directly downstream of the 4-entry Maxnet data memory.
- Reads the four neuron activations through a 2-bit address / 32-bit combinational read port.
- Runs Maxnet lateral-inhibition iterations until at most one neuron stays nonzero, then reports the winner index and its value.
- Controlled by a start/busy/done handshake from the top-level testbench or controller.

Parameters:
- DATA_W, 16: activation width (unsigned); taken from mem_rdata[DATA_W-1:0].
- EPS_SHIFT, 3: inhibition factor epsilon = 2^-EPS_SHIFT (1/8 for 4 neurons).
- MAX_ITER, 64: iteration limit before timeout; counter width is clog2(MAX_ITER+1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin a run; sampled only in IDLE.
- mem_addr  output  2  address to the data memory.
- mem_rdata  input  32  combinational read data, same cycle as mem_addr.
- busy  output  1  high in LOAD and ITER.
- done  output  1  high in DONE; held until the next accepted start.
- winner_valid  output  1  exactly one nonzero neuron at completion.
- winner_idx  output  2  index of the surviving neuron.
- winner_val  output  DATA_W  final activation of the winner.
- timeout  output  1  MAX_ITER was reached without resolution.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; mem_addr 0; activations a[0..3] 0; iteration counter 0.
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE, start=1: go to LOAD; load counter = 0; clear done, winner_*, timeout.
- DONE, start=1: same as IDLE, i.e. a new run begins. start is ignored while busy.
- LOAD (4 cycles):
  - mem_addr = load counter.
  - Each edge captures a[cnt] = mem_rdata[DATA_W-1:0].
  - After the edge that captures cnt=3, go to ITER with iter_cnt = 0.
- ITER (one iteration per cycle, all neurons updated in parallel from the old values):
  - total = a0+a1+a2+a3, computed at DATA_W+2 bits.
  - inh_i = (total - a_i) >> EPS_SHIFT.
  - a_i' = (a_i > inh_i) ? a_i - inh_i : 0. Saturate at 0, never wrap.
  - iter_cnt increments on every ITER edge.
- Termination, evaluated on the new values a':
  - nz = number of nonzero a'.
  - nz <= 1: go to DONE. winner_valid = (nz==1); winner_idx/winner_val = that neuron, else 0.
  - Otherwise, if iter_cnt+1 == MAX_ITER: go to DONE with timeout=1 and winner_valid=0.
  - winner_idx/winner_val are 0 when there is no single winner.
- At least one iteration always runs, even when the loaded data already has nz <= 1. All-zero input finishes after 1 iteration with winner_valid=0.
- Latency: done is visible after edge 4+N, counted from the edge that samples start, where N = number of iterations.
- rst mid-run: immediate return to IDLE with everything cleared. A run is never resumed.

Optional Feature:
- Macro: MAXNET_ITER_COUNT_EN.
- Defined: extra output port iter_count [clog2(MAX_ITER+1)-1:0] carries the number of iterations performed. It is valid while done=1 and cleared on reset and on start.
- Undefined: the port does not exist and the counter is used only internally for timeout.

Decomposition:
- Package maxnet_pkg:
  - FSM state enum (IDLE/LOAD/ITER/DONE).
  - NUM_NEURONS=4 and address width 2.
  - Default DATA_W/EPS_SHIFT/MAX_ITER.
  - Activation array typedef.
- Sub-module maxnet_update: combinational single-iteration datapath. Takes a[0..3] and returns a'[0..3], nz and the winner index. The engine instantiates it once.

Test Plan:
- Memory {0x10,0x20,0x30,0x40}, DATA_W=16, EPS_SHIFT=3, pulse start -> mem_addr steps 0..3; after 8 iterations, done=1, winner_valid=1, winner_idx=3, winner_val=0x26, timeout=0; done visible after edge 12.
- Memory all zero -> done after 1 iteration (edge 5), winner_valid=0, winner_idx=0, winner_val=0.
- Memory {0,0,0x55,0} -> single iteration, winner_idx=2, winner_val=0x55.
- Memory {0x10,0x10,0x10,0x10} -> values settle at 2 each; after 64 iterations timeout=1, winner_valid=0, done=1.
- Assert rst during ITER of the first scenario -> all outputs 0 immediately, state IDLE. A fresh start then reproduces winner 3 / 0x26.
- start pulsed while busy -> ignored, same result. start in DONE -> done clears next cycle and a new run begins.

Source files
------------

// File: rtl/maxnet_pkg.sv
// Shared types and defaults for the Maxnet winner-take-all engine.
package maxnet_pkg;

  localparam int NUM_NEURONS   = 4;
  localparam int ADDR_W        = 2;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_EPS_SHIFT = 3;
  localparam int DEF_MAX_ITER  = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Activation vector at the default width; element i is neuron i.
  typedef logic [NUM_NEURONS-1:0][DEF_DATA_W-1:0] act_arr_t;

endpackage

// File: rtl/maxnet_update.sv
// One Maxnet lateral-inhibition step: all neurons updated from the old values,
// plus the nonzero count and the index of the (last) surviving neuron.
module maxnet_update
  import maxnet_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int EPS_SHIFT = DEF_EPS_SHIFT
) (
  input  logic [NUM_NEURONS-1:0][DATA_W-1:0] act,
  output logic [NUM_NEURONS-1:0][DATA_W-1:0] act_next,
  output logic [2:0]                         nz,
  output logic [ADDR_W-1:0]                  win_idx
);

  localparam int SUM_W = DATA_W + 2;

  logic [SUM_W-1:0] total;

  // Sum of all activations, widened so four full-scale values cannot overflow.
  always_comb begin
    total = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      total = total + {2'b00, act[i]};
    end
  end

  // Inhibit each neuron by eps * (sum of the others), clamping at zero.
  always_comb begin
    logic [SUM_W-1:0] inh;
    inh      = '0;
    act_next = '0;
    nz       = 3'd0;
    win_idx  = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      inh = (total - {2'b00, act[i]}) >> EPS_SHIFT;
      if ({2'b00, act[i]} > inh) begin
        // inh < act[i] here, so the truncation is lossless
        act_next[i] = act[i] - inh[DATA_W-1:0];
        nz          = nz + 3'd1;
        win_idx     = ADDR_W'(i);
      end else begin
        act_next[i] = '0;
      end
    end
  end

endmodule

// File: rtl/maxnet_engine.sv
// Maxnet engine: loads four activations from memory, iterates inhibition until
// at most one neuron survives or MAX_ITER is hit. Optional MAXNET_ITER_COUNT_EN adds iter_count.
module maxnet_engine
  import maxnet_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int EPS_SHIFT = DEF_EPS_SHIFT,
  parameter int MAX_ITER  = DEF_MAX_ITER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              winner_valid,
  output logic [ADDR_W-1:0] winner_idx,
  output logic [DATA_W-1:0] winner_val,
  output logic              timeout
`ifdef MAXNET_ITER_COUNT_EN
  ,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_count
`endif
);

  localparam int CNT_W = $clog2(MAX_ITER + 1);

  state_t                            state_r;
  state_t                            state_nx;
  logic [ADDR_W-1:0]                 load_cnt_r;
  logic [CNT_W-1:0]                  iter_cnt_r;
  logic [NUM_NEURONS-1:0][DATA_W-1:0] act_r;
  logic [NUM_NEURONS-1:0][DATA_W-1:0] act_next;
  logic [2:0]                        nz;
  logic [ADDR_W-1:0]                 win_idx;
  logic                              resolved;
  logic                              last_iter;
  logic                              winner_valid_r;
  logic [ADDR_W-1:0]                 winner_idx_r;
  logic [DATA_W-1:0]                 winner_val_r;
  logic                              timeout_r;
  logic                              unused_rdata;

  assign unused_rdata = ^mem_rdata[31:DATA_W];

  maxnet_update #(
    .DATA_W    (DATA_W),
    .EPS_SHIFT (EPS_SHIFT)
  ) u_update (
    .act      (act_r),
    .act_next (act_next),
    .nz       (nz),
    .win_idx  (win_idx)
  );

  assign resolved  = (nz <= 3'd1);
  assign last_iter = (iter_cnt_r == CNT_W'(MAX_ITER - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic; start is only honoured when not busy.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) state_nx = ST_LOAD;
        else       state_nx = state_r;
      end
      ST_LOAD: begin
        if (load_cnt_r == 2'd3) state_nx = ST_ITER;
        else                    state_nx = ST_LOAD;
      end
      ST_ITER: begin
        if (resolved || last_iter) state_nx = ST_DONE;
        else                       state_nx = ST_ITER;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Load counter, activations, iteration counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt_r     <= '0;
      iter_cnt_r     <= '0;
      act_r          <= '0;
      winner_valid_r <= 1'b0;
      winner_idx_r   <= '0;
      winner_val_r   <= '0;
      timeout_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            load_cnt_r     <= '0;
            iter_cnt_r     <= '0;
            winner_valid_r <= 1'b0;
            winner_idx_r   <= '0;
            winner_val_r   <= '0;
            timeout_r      <= 1'b0;
          end
        end
        ST_LOAD: begin
          act_r[load_cnt_r] <= mem_rdata[DATA_W-1:0];
          load_cnt_r        <= load_cnt_r + 2'd1;
          iter_cnt_r        <= '0;
        end
        ST_ITER: begin
          act_r      <= act_next;
          iter_cnt_r <= iter_cnt_r + CNT_W'(1);
          if (resolved) begin
            winner_valid_r <= (nz == 3'd1);
            winner_idx_r   <= (nz == 3'd1) ? win_idx : '0;
            winner_val_r   <= (nz == 3'd1) ? act_next[win_idx] : '0;
          end else if (last_iter) begin
            timeout_r <= 1'b1;
          end
        end
        default: begin
          load_cnt_r <= '0;
        end
      endcase
    end
  end

  assign mem_addr     = load_cnt_r;
  assign busy         = (state_r == ST_LOAD) || (state_r == ST_ITER);
  assign done         = (state_r == ST_DONE);
  assign winner_valid = winner_valid_r;
  assign winner_idx   = winner_idx_r;
  assign winner_val   = winner_val_r;
  assign timeout      = timeout_r;
`ifdef MAXNET_ITER_COUNT_EN
  assign iter_count   = iter_cnt_r;
`endif

endmodule
